// File: rtl/word_sequencer.sv
// -----------------------------------------------------------------------------
// word_sequencer
//
// Snapshots a DEPTH-entry bank of WIDTH-bit words on `start` and streams them
// out highest index first over a valid/ready handshake. Supports one-shot and
// continuous-loop operation and a synchronous abort.
//
// Optional feature macro: WORD_SEQ_SKIP_EN
//   When defined, a per-word `skip` mask is captured with `start`; masked
//   words are never presented. An all-ones mask goes straight to DONE.
//   When undefined, there is no `skip` port and every word is emitted.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   start    in   begin a sequence (honoured only in IDLE)
//   abort    in   synchronous abandon, wins over start and transfer
//   loop     in   captured with start: 0 = one-shot, 1 = wrap continuously
//   data     in   DEPTH*WIDTH word bank, word i at bits [i*WIDTH +: WIDTH]
//   skip     in   DEPTH-bit skip mask (WORD_SEQ_SKIP_EN only)
//   o_valid  out  `o` holds a word
//   o_ready  in   consumer accepts the word on `o`
//   o        out  current word, 0 when o_valid = 0
//   idx      out  index of the word on `o`
//   busy     out  state is not IDLE
//   done     out  one-cycle pulse at the end of a one-shot sequence
//   passes   out  completed full passes since the last start (wraps)
// -----------------------------------------------------------------------------
module word_sequencer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   loop,
   input  logic [DEPTH*WIDTH-1:0] data,
`ifdef WORD_SEQ_SKIP_EN
   input  logic [DEPTH-1:0]       skip,
`endif
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [WIDTH-1:0]       o,
   output logic [IW-1:0]          idx,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            passes
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q;
   logic [WIDTH-1:0] snap_q [DEPTH];
   logic [DEPTH-1:0] mask_q;
   logic             loop_q;
   logic [IW-1:0]    idx_q;
   logic [15:0]      passes_q;

   // Mask presented at capture time. Without the skip feature it is all
   // zeros, so every word is unmasked and the index logic reduces to a
   // plain down-counter.
   logic [DEPTH-1:0] skip_cap;
`ifdef WORD_SEQ_SKIP_EN
   assign skip_cap = skip;
`else
   assign skip_cap = '0;
`endif

   // Index search over the mask:
   //   cap_first - highest unmasked index of the incoming mask (first word)
   //   wrap_idx  - highest unmasked index of the captured mask (loop wrap)
   //   next_idx  - highest unmasked index strictly below idx_q (next word);
   //               has_next = 0 means the current word ends the pass.
   logic [IW-1:0] cap_first;
   logic          cap_any;
   logic [IW-1:0] wrap_idx;
   logic [IW-1:0] next_idx;
   logic          has_next;

   // NOTE: every always_comb output is given a default before the loop so no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      cap_first = '0;
      cap_any   = 1'b0;
      wrap_idx  = '0;
      next_idx  = '0;
      has_next  = 1'b0;
      // Ascending scan: the last hit wins, giving the highest qualifying index.
      for (int i = 0; i < DEPTH; i++) begin
         if (!skip_cap[i]) begin
            cap_first = IW'(i);
            cap_any   = 1'b1;
         end
         if (!mask_q[i]) begin
            wrap_idx = IW'(i);
         end
         if (!mask_q[i] && (i < int'(idx_q))) begin
            next_idx = IW'(i);
            has_next = 1'b1;
         end
      end
   end

   // NOTE: the snapshot buffer is reset along with the control state so `o`
   // can never expose stale contents; it is small enough that this is cheap.
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         loop_q   <= 1'b0;
         idx_q    <= '0;
         passes_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            snap_q[i] <= '0;
         end
      end else if (abort) begin
         // Abort wins over start and over a simultaneous transfer; passes hold.
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     snap_q[i] <= data[i*WIDTH +: WIDTH];
                  end
                  mask_q   <= skip_cap;
                  loop_q   <= loop;
                  passes_q <= '0;
                  if (cap_any) begin
                     state_q <= S_RUN;
                     idx_q   <= cap_first;
                  end else begin
                     // Nothing to emit: finish immediately, even in loop mode.
                     state_q <= S_DONE;
                     idx_q   <= IW'(DEPTH - 1);
                  end
               end
            end
            S_RUN: begin
               if (o_ready) begin
                  if (has_next) begin
                     idx_q <= next_idx;
                  end else begin
                     passes_q <= passes_q + 16'd1;
                     if (loop_q) begin
                        idx_q <= wrap_idx;
                     end else begin
                        state_q <= S_DONE;
                     end
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from registered state only; o_ready never reaches
   // o_valid combinationally.
   assign o_valid = (state_q == S_RUN);
   assign o       = o_valid ? snap_q[idx_q] : '0;
   assign idx     = idx_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign passes  = passes_q;

endmodule
